// File: rtl/bcd_convert_arbiter_pkg.sv
// Shared types and constants for the shared binary-to-BCD converter.
package bcd_convert_arbiter_pkg;

    // Converter sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Digits at or above this value get +3 before each shift
    localparam int unsigned ADD3_THRESHOLD = 5;

    // Requester indices
    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    // Single-digit double-dabble correction
    function automatic logic [3:0] dabble_digit(input logic [3:0] d);
        return (d >= 4'(ADD3_THRESHOLD)) ? (d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/bcd_convert_arbiter_dabble_step.sv
// Combinational add-3 stage applied to every BCD digit in parallel.
module bcd_dabble_step
    import bcd_convert_arbiter_pkg::*;
#(
    parameter int unsigned DIGITS = 10
) (
    input  logic [4*DIGITS-1:0] i_digits,
    output logic [4*DIGITS-1:0] o_digits
);

    // Correct each nibble independently
    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
        assign o_digits[4*g +: 4] = dabble_digit(i_digits[4*g +: 4]);
    end

endmodule

// File: rtl/bcd_convert_arbiter.sv
// Round-robin shared iterative double-dabble binary-to-BCD converter.
module bcd_convert_arbiter
    import bcd_convert_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DIGITS = 10,
    parameter int unsigned SIGNED = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            req,
    input  logic [WIDTH-1:0]      data0,
    input  logic [WIDTH-1:0]      data1,
    output logic [1:0]            gnt,
    output logic                  busy,
    output logic                  done,
    output logic                  done_id,
    output logic                  neg,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int unsigned BCD_W = 4 * DIGITS;

    state_t             r_state;
    state_t             w_state_next;
    logic [1:0]         w_gnt;
    logic               w_sel;
    logic               r_prio;
    logic [WIDTH-1:0]   r_op;
    logic [WIDTH-1:0]   r_mag;
    logic [BCD_W-1:0]   r_acc;
    logic [BCD_W-1:0]   w_adj;
    logic [BCD_W-1:0]   w_acc_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_id;
    logic               r_neg_work;
    logic               r_busy;
    logic               r_done;
    logic               r_done_id;
    logic               r_neg;
    logic [BCD_W-1:0]   r_bcd;

    bcd_dabble_step #(
        .DIGITS   (DIGITS)
    ) u_step (
        .i_digits (r_acc),
        .o_digits (w_adj)
    );

    // Adjusted accumulator shifted left with the magnitude MSB entering digit 0
    assign w_acc_next = (w_adj << 1) | {{(BCD_W-1){1'b0}}, r_mag[WIDTH-1]};

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and same-cycle grant
    always_comb begin
        w_state_next = r_state;
        w_gnt        = 2'b00;
        w_sel        = r_prio;
        case (r_state)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    w_sel        = (req == 2'b11) ? r_prio : req[REQ_DBG];
                    w_gnt[w_sel] = 1'b1;
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD:  w_state_next = ST_SHIFT;
            ST_SHIFT: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
        if (!reset_n) begin
            w_gnt = 2'b00;
        end
    end

    // Arbiter pointer, operand capture, conversion datapath and result registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_prio     <= REQ_ALU;
            r_op       <= '0;
            r_mag      <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_id       <= 1'b0;
            r_neg_work <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_done_id  <= 1'b0;
            r_neg      <= 1'b0;
            r_bcd      <= '0;
        end else begin
            r_done <= 1'b0;
            r_busy <= (w_state_next != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (req != 2'b00) begin
                        r_op   <= w_sel ? data1 : data0;
                        r_id   <= w_sel;
                        r_prio <= ~w_sel;
                    end
                end
                ST_LOAD: begin
                    if ((SIGNED != 0) && r_op[WIDTH-1]) begin
                        r_mag      <= ~r_op + WIDTH'(1);
                        r_neg_work <= 1'b1;
                    end else begin
                        r_mag      <= r_op;
                        r_neg_work <= 1'b0;
                    end
                    r_acc <= '0;
                    r_cnt <= CNT_W'(WIDTH - 1);
                end
                ST_SHIFT: begin
                    r_acc <= w_acc_next;
                    r_mag <= r_mag << 1;
                    if (r_cnt == '0) begin
                        r_bcd     <= w_acc_next;
                        r_neg     <= r_neg_work;
                        r_done_id <= r_id;
                        r_done    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign gnt     = w_gnt;
    assign busy    = r_busy;
    assign done    = r_done;
    assign done_id = r_done_id;
    assign neg     = r_neg;
    assign bcd     = r_bcd;

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Randomized and directed bench for the shared BCD converter (signed and unsigned builds).
module tb_bcd_convert_arbiter;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned DIGITS = 10;
    localparam int          LAT    = WIDTH + 2;

    logic        clk;
    logic        reset_n;
    logic [1:0]  req;
    logic [31:0] data0;
    logic [31:0] data1;

    logic [1:0]  gnt,  gnt_u;
    logic        busy, busy_u;
    logic        done, done_u;
    logic        done_id, done_id_u;
    logic        neg, neg_u;
    logic [39:0] bcd, bcd_u;

    int total = 0;
    int bad   = 0;

    bcd_convert_arbiter #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SIGNED(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .req(req), .data0(data0), .data1(data1),
        .gnt(gnt), .busy(busy), .done(done), .done_id(done_id), .neg(neg), .bcd(bcd)
    );

    bcd_convert_arbiter #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SIGNED(0)) u_dut_u (
        .clk(clk), .reset_n(reset_n), .req(req), .data0(data0), .data1(data1),
        .gnt(gnt_u), .busy(busy_u), .done(done_u), .done_id(done_id_u), .neg(neg_u), .bcd(bcd_u)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference conversion by plain decimal arithmetic
    function automatic void convert(input logic [31:0] x, input bit sgn,
                                    output logic n, output logic [39:0] b);
        longint v;
        v = sgn ? longint'($signed(x)) : longint'({32'd0, x});
        n = (v < 0);
        if (v < 0) v = -v;
        b = '0;
        for (int i = 0; i < 10; i++) begin
            b[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
    endfunction

    // Cycle-level transaction model and per-cycle compare
    initial begin : cmp
        int          since;
        bit          last;
        bit          sel;
        logic [1:0]  eg;
        logic        p_id, p_neg, p_neg_u;
        logic [39:0] p_bcd, p_bcd_u;
        logic        e_id, e_neg, e_neg_u;
        logic [39:0] e_bcd, e_bcd_u;
        since = 0; last = 1'b1;
        p_id = 0; p_neg = 0; p_neg_u = 0; p_bcd = '0; p_bcd_u = '0;
        e_id = 0; e_neg = 0; e_neg_u = 0; e_bcd = '0; e_bcd_u = '0;
        @(negedge clk);
        forever begin
            eg = 2'b00;
            sel = 1'b0;
            if (since == 0 && req != 2'b00) begin
                sel = (req == 2'b11) ? !last : req[1];
                eg  = sel ? 2'b10 : 2'b01;
            end
            if (reset_n) begin
                check("gnt", gnt, eg);
                check("gnt_u", gnt_u, eg);
            end
            check("busy", busy, since > 0);
            check("busy_u", busy_u, since > 0);
            check("done", done, since == LAT);
            check("done_u", done_u, since == LAT);
            check("done_id", done_id, e_id);
            check("done_id_u", done_id_u, e_id);
            check("neg", neg, e_neg);
            check("neg_u", neg_u, e_neg_u);
            check("bcd", bcd, e_bcd);
            check("bcd_u", bcd_u, e_bcd_u);
            if (!reset_n) begin
                since = 0; last = 1'b1;
                e_id = 0; e_neg = 0; e_neg_u = 0; e_bcd = '0; e_bcd_u = '0;
            end else if (since == 0) begin
                if (req != 2'b00) begin
                    p_id = sel;
                    convert(sel ? data1 : data0, 1'b1, p_neg, p_bcd);
                    convert(sel ? data1 : data0, 1'b0, p_neg_u, p_bcd_u);
                    last  = sel;
                    since = 1;
                end
            end else if (since == LAT) begin
                since = 0;
            end else begin
                since++;
                if (since == LAT) begin
                    e_id = p_id; e_neg = p_neg; e_neg_u = p_neg_u;
                    e_bcd = p_bcd; e_bcd_u = p_bcd_u;
                end
            end
            @(negedge clk);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input int id, input logic [31:0] val);
        bit ok;
        step();
        if (id == 0) data0 = val; else data1 = val;
        req[id] = 1'b1;
        ok = 0;
        for (int i = 0; i < 80 && !ok; i++) begin
            @(negedge clk);
            if (gnt[id]) ok = 1;
        end
        check("grant_seen", 64'(ok), 64'd1);
        step();
        req[id] = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int i = 0; i < 80 && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1;
        end
        check("done_seen", 64'(ok), 64'd1);
    endtask

    task automatic do_reset(input int cycles);
        step();
        reset_n = 1'b0;
        req = 2'b00;
        repeat (cycles) step();
        reset_n = 1'b1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic        n;
        logic [39:0] b;
        int          gids[$];
        int          dcyc[$];
        int          dids[$];
        logic [39:0] dbcd[$];
        int          cyc;
        int          dones;

        reset_n = 1'b0; req = 2'b00; data0 = '0; data1 = '0;

        // Pin the reference conversion against hand-computed values
        convert(32'd1234, 1'b1, n, b);       check("model_1234", {n, b}, {1'b0, 40'h0000001234});
        convert(32'hFFFFFF85, 1'b1, n, b);   check("model_m123", {n, b}, {1'b1, 40'h0000000123});
        convert(32'h80000000, 1'b1, n, b);   check("model_min", {n, b}, {1'b1, 40'h2147483648});
        convert(32'hFFFFFFFF, 1'b0, n, b);   check("model_umax", {n, b}, {1'b0, 40'h4294967295});

        repeat (2) step();
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bcd", bcd, 40'h0);

        request(0, 32'd1234);
        wait_done();
        check("d1234_id", done_id, 0); check("d1234_neg", neg, 0); check("d1234_bcd", bcd, 40'h1234);

        request(1, 32'hFFFFFF85);
        wait_done();
        check("dm123_id", done_id, 1); check("dm123_neg", neg, 1); check("dm123_bcd", bcd, 40'h123);

        request(0, 32'h80000000);
        wait_done();
        check("dmin_neg", neg, 1); check("dmin_bcd", bcd, 40'h2147483648);
        check("dmin_bcd_u", bcd_u, 40'h2147483648); check("dmin_neg_u", neg_u, 0);

        request(1, 32'hFFFFFFFF);
        wait_done();
        check("umax_bcd_u", bcd_u, 40'h4294967295); check("umax_neg_u", neg_u, 0);
        check("umax_bcd_s", bcd, 40'h1); check("umax_neg_s", neg, 1);

        request(0, 32'd0);
        wait_done();
        check("zero_bcd", bcd, 40'h0); check("zero_neg", neg, 0);

        // Contention from a fresh reset
        do_reset(1);
        step();
        data0 = 32'd5; data1 = 32'd9; req = 2'b11;
        cyc = 0; dones = 0;
        while (dones < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (gnt != 2'b00) gids.push_back(gnt[1] ? 1 : 0);
            if (done) begin
                dcyc.push_back(cyc); dids.push_back(int'(done_id)); dbcd.push_back(bcd);
                dones++;
            end
            if (gids.size() == 3 && req != 2'b00) begin
                step();
                req = 2'b00;
            end
        end
        check("cont_dones", dones, 3);
        if (gids.size() == 3 && dones == 3) begin
            check("cont_g0", gids[0], 0); check("cont_g1", gids[1], 1); check("cont_g2", gids[2], 0);
            check("cont_gap1", dcyc[1] - dcyc[0], 35); check("cont_gap2", dcyc[2] - dcyc[1], 35);
            check("cont_id0", dids[0], 0); check("cont_id1", dids[1], 1); check("cont_id2", dids[2], 0);
            check("cont_v0", dbcd[0], 40'h5); check("cont_v1", dbcd[1], 40'h9); check("cont_v2", dbcd[2], 40'h5);
        end

        // Reset during the 10th shift cycle abandons the conversion
        request(0, 32'd99999);
        repeat (9) step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 0); check("midrst_bcd", bcd, 40'h0); check("midrst_done", done, 0);
        dones = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("midrst_nodone", dones, 0);
        request(0, 32'd7);
        wait_done();
        check("after_rst_bcd", bcd, 40'h7);

        // Data changing after grant, second requester arriving while busy
        step();
        data0 = 32'd42; req = 2'b01;
        @(negedge clk);
        check("hold_gnt", gnt, 2'b01);
        step();
        req = 2'b10; data0 = 32'd99; data1 = 32'd321;
        @(negedge clk);
        check("hold_nogrant_busy", gnt, 2'b00);
        wait_done();
        check("hold_bcd", bcd, 40'h42); check("hold_id", done_id, 0);
        @(negedge clk);
        check("after_done_gnt", gnt, 2'b10);
        step();
        req = 2'b00;
        wait_done();
        check("second_bcd", bcd, 40'h321); check("second_id", done_id, 1);

        // Randomized traffic checked by the model
        for (int c = 0; c < 2000; c++) begin
            step();
            reset_n = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 7) == 0) req = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 5))
                    0: data0 = 32'h80000000;
                    1: data0 = 32'hFFFFFFFF;
                    2: data0 = 32'd0;
                    default: data0 = $urandom;
                endcase
            end
            if ($urandom_range(0, 3) == 0) data1 = $urandom;
        end
        step();
        req = 2'b00; reset_n = 1'b1;
        repeat (40) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_convert_arbiter.md
Name: bcd_convert_arbiter

Overview:
- Shares one iterative double-dabble binary-to-BCD engine between two requesters, e.g. a register-file debug port and the ALU result tap feeding the 7-segment display.
- Arbitrates round-robin between the requesters and sequences the engine one bit per clock, which replaces a fully unrolled combinational converter.
- Presents the signed decimal result with a one-cycle done pulse tagged with the requester ID.

Parameters:
- WIDTH, 32, binary operand width; must be ≥ 2.
- DIGITS, 10, number of BCD digits; must satisfy 10^DIGITS > 2^WIDTH.
- SIGNED, 1, 1 = treat operand bit WIDTH-1 as the sign; 0 = unsigned.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous active-low reset; one clock; reset is synchronous and active-low.
- req  in  2  per-requester conversion request; level, held until granted.
- data0  in  WIDTH  operand of requester 0, sampled in its grant cycle.
- data1  in  WIDTH  operand of requester 1, sampled in its grant cycle.
- gnt  out  2  one-hot grant pulse, one cycle.
- busy  out  1  high from the cycle after a grant through the done cycle.
- done  out  1  one-cycle pulse when a result is valid.
- done_id  out  1  requester index of the current result.
- neg  out  1  sign of the current result.
- bcd  out  4*DIGITS  result digits; nibble 0 is the least significant digit.

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE; gnt=0, busy=0, done=0, done_id=0, neg=0, bcd=0, shift count=0; round-robin pointer favours requester 0. This applies mid-conversion: an in-flight conversion is abandoned with no done pulse.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - If any req bit is high, drive gnt one-hot combinationally in the same cycle.
  - At the edge, capture the selected data into the operand register, record id, go to LOAD.
  - If req=0, stay in IDLE.
- Arbitration:
  - Only one requester: grant it.
  - Both requesters: grant the one not granted last.
  - First grant after reset with both requesting goes to 0.
  - Pointer updates only on a grant.
- LOAD (1 cycle):
  - If SIGNED=1 and operand[WIDTH-1]=1: magnitude = two's complement negation (~x+1) and neg_next=1.
  - Otherwise magnitude = operand and neg_next=0.
  - Clear the digit accumulator; count = WIDTH-1; go to SHIFT.
  - The most negative value -2^(WIDTH-1) negates to itself and is then interpreted as unsigned, which is correct.
- SHIFT (exactly WIDTH cycles):
  - Per cycle, first add 3 to every accumulator digit ≥ 5 (all digits in parallel).
  - Then shift the {accumulator, magnitude} concatenation left by 1, so the magnitude MSB enters digit 0 bit 0.
  - When count=0, go to DONE; otherwise decrement count.
- DONE (1 cycle):
  - done=1; bcd, neg and done_id update at the edge entering DONE and hold until the next DONE.
  - Return to IDLE.
  - No grant is issued in DONE, so back-to-back conversions are spaced WIDTH+3 cycles apart.
- Latency: a grant in cycle T gives done=1 in cycle T+WIDTH+2 (T+34 for WIDTH=32).
- busy is 1 in the LOAD, SHIFT and DONE states; gnt is never asserted while busy.
- A requester that drops req before being granted is never served; there is no queuing.
- data changing after the grant cycle has no effect on the in-flight result.
- Digits above the most significant nonzero digit read as 0; there is no blanking logic in this block.

Decomposition:
- Shared package: FSM state encoding (IDLE, LOAD, SHIFT, DONE), the constant ADD3_THRESHOLD=5, and the requester ID constants REQ_ALU=0, REQ_DBG=1.
- Sub-module bcd_dabble_step: purely combinational, DIGITS-wide add-3 stage (digits in, adjusted digits out). The top module instantiates it inside the SHIFT datapath and keeps the FSM, arbiter, counter and registers itself.

Test Plan:
- Single request: req=01, data0=32'd1234 → gnt=01 for one cycle; 34 cycles later done=1, done_id=0, neg=0, bcd=...0001_0010_0011_0100.
- Negative input: req=10, data1=32'hFFFFFF85 (-123), SIGNED=1 → done_id=1, neg=1, bcd digits 1,2,3; upper digits 0.
- Extremes:
  - 32'h80000000 → neg=1, bcd=2147483648.
  - 32'hFFFFFFFF with SIGNED=0 → neg=0, bcd=4294967295.
  - 0 → bcd all zero, neg=0.
- Contention: req=11 held continuously with data0=5 and data1=9 → grants alternate 0,1,0; consecutive done pulses are 35 cycles apart; results alternate 5/9 with matching done_id.
- Reset mid-op: reset_n=0 for 1 cycle at the 10th SHIFT cycle → next cycle busy=0, bcd=0, no done pulse. A subsequent req=01, data0=7 completes normally with bcd=7.
- Data hold: data0 changes from 42 to 99 one cycle after the grant → result is 42; requester 1 raising req during busy is granted only after DONE.
